// File: rtl/life_sequencer.sv
// life_sequencer: run-control FSM pacing the 8x8 Game-of-Life grid flop, counting generations, detecting halts.
// Latency: a control pulse on cycle N takes effect on cycle N+1; RUN commits one generation every TICK_DIV cycles.
// Backpressure: none; control inputs are one-cycle pulses, and lower-priority pulses arriving in the same cycle are dropped.
module life_sequencer #(
  parameter int TICK_DIV  = 25_000_000,
  parameter int GEN_W     = 16,
  parameter int GEN_LIMIT = 0
) (
  input  logic             clk,
  input  logic             flopreset,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic             clear,
  input  logic [63:0]      grid_cur,
  input  logic [63:0]      grid_next,
  output logic             load_sel,
  output logic             grid_we,
  output logic             show_grid,
  output logic [GEN_W-1:0] gen_count,
  output logic [2:0]       state,
  output logic             extinct,
  output logic             stable,
  output logic             osc2
);

  localparam int              TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_STEP  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t            cur_st;
  state_t            nxt_st;
  logic [TICK_W-1:0] tick;
  logic [63:0]       prev;
  logic              prev_valid;
  logic              commit;
  logic              tick_run;
  logic              tick_end;
  logic [GEN_W:0]    gen_plus1;
  logic              hit_ext;
  logic              hit_stab;
  logic              hit_osc;
  logic              hit_lim;
  logic              halt_hit;

  assign tick_end  = (tick == TICK_LAST);
  assign gen_plus1 = {1'b0, gen_count} + (GEN_W+1)'(1);

  // Halt conditions evaluated against the generation about to be committed.
  assign hit_ext  = (grid_next == 64'd0);
  assign hit_stab = (grid_next == grid_cur);
  assign hit_osc  = prev_valid && (grid_next == prev);
  assign hit_lim  = (GEN_LIMIT != 0) && (gen_plus1 == (GEN_W+1)'(GEN_LIMIT));
  assign halt_hit = hit_ext || hit_stab || hit_osc || hit_lim;

  // State register.
  always_ff @(posedge clk) begin
    if (flopreset) cur_st <= S_IDLE;
    else           cur_st <= nxt_st;
  end

  // Next state and commit decision; clear > start > pause > step.
  always_comb begin
    nxt_st   = cur_st;
    commit   = 1'b0;
    tick_run = 1'b0;
    case (cur_st)
      S_IDLE: begin
        if (clear)      nxt_st = S_IDLE;
        else if (start) nxt_st = S_LOAD;
      end
      S_LOAD: begin
        nxt_st = clear ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (clear)      nxt_st = S_IDLE;
        else if (start) nxt_st = S_LOAD;
        else if (pause) nxt_st = S_PAUSE;
        else begin
          tick_run = 1'b1;
          commit   = tick_end;
        end
      end
      S_PAUSE: begin
        if (clear)      nxt_st = S_IDLE;
        else if (start) nxt_st = S_LOAD;
        else if (pause) nxt_st = S_RUN;
        else if (step)  nxt_st = S_STEP;
      end
      S_STEP: begin
        if (clear)      nxt_st = S_IDLE;
        else if (start) nxt_st = S_LOAD;
        else begin
          commit = 1'b1;
          nxt_st = S_PAUSE;
        end
      end
      S_HALT: begin
        if (clear)      nxt_st = S_IDLE;
        else if (start) nxt_st = S_LOAD;
      end
      default: nxt_st = S_IDLE;
    endcase
    if (commit && halt_hit) nxt_st = S_HALT;
  end

  // Tick pacing, generation count, history and sticky halt flags.
  always_ff @(posedge clk) begin
    if (flopreset) begin
      tick       <= '0;
      gen_count  <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      extinct    <= 1'b0;
      stable     <= 1'b0;
      osc2       <= 1'b0;
    end else if (clear || cur_st == S_LOAD) begin
      tick       <= '0;
      gen_count  <= '0;
      prev_valid <= 1'b0;
      extinct    <= 1'b0;
      stable     <= 1'b0;
      osc2       <= 1'b0;
    end else begin
      if (tick_run) tick <= tick_end ? '0 : tick + TICK_W'(1);
      if (commit) begin
        prev       <= grid_cur;
        prev_valid <= 1'b1;
        if (gen_count != {GEN_W{1'b1}}) gen_count <= gen_plus1[GEN_W-1:0];
        if (hit_ext)       extinct <= 1'b1;
        else if (hit_stab) stable  <= 1'b1;
        else if (hit_osc)  osc2    <= 1'b1;
      end
    end
  end

  // Outputs decoded from the registered state; a clear suppresses the LOAD write.
  always_comb begin
    grid_we   = !flopreset && (commit || (cur_st == S_LOAD && !clear));
    load_sel  = (cur_st == S_IDLE) || (cur_st == S_LOAD);
    show_grid = (cur_st != S_IDLE);
    state     = cur_st;
  end

endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: models the grid flop and evolve datapath, scoreboards grid writes.
// Expected write cycles are queued when stimulus is driven and matched as the DUT asserts grid_we.
// A second instance with a generation limit of 3 covers the limit halt.
module tb_life_sequencer;
  localparam int GW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic flopreset = 1'b1;
  logic start = 1'b0, pause = 1'b0, step = 1'b0, clear = 1'b0;
  logic lstart = 1'b0, lclear = 1'b0, lzero = 1'b0;
  logic [63:0] seed = '0;
  logic [63:0] grid_m = '0, gnext_m, grid_l = '0, gnext_l;

  logic          load_sel, grid_we, show_grid, extinct, stable, osc2;
  logic [GW-1:0] gen_count;
  logic [2:0]    state;
  logic          l_load_sel, l_grid_we, l_show_grid, l_extinct, l_stable, l_osc2;
  logic [GW-1:0] l_gen_count;
  logic [2:0]    l_state;

  typedef struct { int c; logic ls; } wexp_t;
  wexp_t expq[$];
  int cyc = 0, n_chk = 0, n_pass = 0;

  localparam int P_START = 0, P_PAUSE = 1, P_STEP = 2, P_CLEAR = 3, P_LSTART = 4, P_LCLEAR = 5;

  life_sequencer #(.TICK_DIV(4), .GEN_W(GW), .GEN_LIMIT(0)) u_dut (
    .clk(clk), .flopreset(flopreset), .start(start), .pause(pause), .step(step), .clear(clear),
    .grid_cur(grid_m), .grid_next(gnext_m), .load_sel(load_sel), .grid_we(grid_we),
    .show_grid(show_grid), .gen_count(gen_count), .state(state),
    .extinct(extinct), .stable(stable), .osc2(osc2));

  life_sequencer #(.TICK_DIV(4), .GEN_W(GW), .GEN_LIMIT(3)) u_lim (
    .clk(clk), .flopreset(flopreset), .start(lstart), .pause(lzero), .step(lzero), .clear(lclear),
    .grid_cur(grid_l), .grid_next(gnext_l), .load_sel(l_load_sel), .grid_we(l_grid_we),
    .show_grid(l_show_grid), .gen_count(l_gen_count), .state(l_state),
    .extinct(l_extinct), .stable(l_stable), .osc2(l_osc2));

  // Reference evolve: 8x8 board, cells outside the board are dead.
  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] o;
    int n;
    o = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              n += int'(g[(r + dr) * 8 + c + dc]);
        o[r * 8 + c] = (n == 3) || (g[r * 8 + c] && n == 2);
      end
    end
    return o;
  endfunction

  function automatic logic [63:0] evolve_n(input logic [63:0] g, input int n);
    logic [63:0] x;
    x = g;
    for (int i = 0; i < n; i++) x = life(x);
    return x;
  endfunction

  function automatic logic [63:0] glider();
    logic [63:0] g;
    g = '0;
    g[1] = 1'b1; g[10] = 1'b1; g[16] = 1'b1; g[17] = 1'b1; g[18] = 1'b1;
    return g;
  endfunction

  always_comb gnext_m = life(grid_m);
  always_comb gnext_l = life(grid_l);

  // Grid flops fed by the seed/feedback mux.
  always @(posedge clk) begin
    if (grid_we)   grid_m <= load_sel ? seed : gnext_m;
    if (l_grid_we) grid_l <= l_load_sel ? seed : gnext_l;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic mon();
    wexp_t e;
    while (expq.size() > 0 && expq[0].c < cyc) begin
      e = expq.pop_front();
      chk("we_missing", 64'd0, 64'd1);
    end
    if (grid_we) begin
      if (expq.size() == 0) chk("we_unexpected", 64'd1, 64'd0);
      else begin
        e = expq.pop_front();
        chk("we_cycle", 64'(cyc), 64'(e.c));
        chk("we_load_sel", 64'(load_sel), 64'(e.ls));
      end
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) next_cyc();
  endtask

  task automatic pulse(input int which);
    case (which)
      P_START:  start  = 1'b1;
      P_PAUSE:  pause  = 1'b1;
      P_STEP:   step   = 1'b1;
      P_CLEAR:  clear  = 1'b1;
      P_LSTART: lstart = 1'b1;
      default:  lclear = 1'b1;
    endcase
    next_cyc();
    start = 1'b0; pause = 1'b0; step = 1'b0; clear = 1'b0; lstart = 1'b0; lclear = 1'b0;
  endtask

  task automatic push_we(input int c, input logic ls);
    expq.push_back('{c: c, ls: ls});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_load_sel"}, 64'(load_sel), 64'd1);
    chk({tag, "_grid_we"}, 64'(grid_we), 64'd0);
    chk({tag, "_show_grid"}, 64'(show_grid), 64'd0);
    chk({tag, "_gen"}, 64'(gen_count), 64'd0);
    chk({tag, "_flags"}, 64'({extinct, stable, osc2}), 64'd0);
  endtask

  initial begin
    int b, s, p, q;
    next_cyc();
    next_cyc();
    flopreset = 1'b0;
    chk_reset_vals("rst");

    // 1: glider runs, LOAD then commits every 4 cycles.
    seed = glider();
    b = cyc;
    push_we(b + 1, 1'b1); push_we(b + 5, 1'b0); push_we(b + 9, 1'b0); push_we(b + 13, 1'b0);
    pulse(P_START);
    chk("t1_load_state", 64'(state), 64'd1);
    chk("t1_load_we", 64'(grid_we), 64'd1);
    chk("t1_load_show", 64'(show_grid), 64'd1);
    run_to(b + 6);  chk("t1_gen1", 64'(gen_count), 64'd1);
    run_to(b + 10); chk("t1_gen2", 64'(gen_count), 64'd2);
    run_to(b + 14); chk("t1_gen3", 64'(gen_count), 64'd3);
    chk("t1_grid", grid_m, evolve_n(glider(), 3));
    pulse(P_CLEAR);
    chk("t1_clr_state", 64'(state), 64'd0);
    chk("t1_clr_gen", 64'(gen_count), 64'd0);

    // 2: single cell dies out at generation 1.
    seed = '0; seed[27] = 1'b1;
    b = cyc;
    push_we(b + 1, 1'b1); push_we(b + 5, 1'b0);
    pulse(P_START);
    run_to(b + 6);
    chk("t2_extinct", 64'(extinct), 64'd1);
    chk("t2_other", 64'({stable, osc2}), 64'd0);
    chk("t2_gen", 64'(gen_count), 64'd1);
    chk("t2_state", 64'(state), 64'd5);
    run_to(b + 16);
    chk("t2_hold_gen", 64'(gen_count), 64'd1);

    // 3a: block is a still life.
    seed = '0; seed[27] = 1'b1; seed[28] = 1'b1; seed[35] = 1'b1; seed[36] = 1'b1;
    b = cyc;
    push_we(b + 1, 1'b1); push_we(b + 5, 1'b0);
    pulse(P_START);
    next_cyc();
    chk("t3_flags_cleared", 64'({extinct, stable, osc2}), 64'd0);
    chk("t3_gen_cleared", 64'(gen_count), 64'd0);
    run_to(b + 6);
    chk("t3_stable", 64'({extinct, stable, osc2}), 64'b010);
    chk("t3_state", 64'(state), 64'd5);

    // 3b: blinker oscillates with period 2.
    seed = '0; seed[26] = 1'b1; seed[27] = 1'b1; seed[28] = 1'b1;
    b = cyc;
    push_we(b + 1, 1'b1); push_we(b + 5, 1'b0); push_we(b + 9, 1'b0);
    pulse(P_START);
    run_to(b + 6);
    chk("t3_blk_run", 64'(state), 64'd2);
    run_to(b + 10);
    chk("t3_osc2", 64'({extinct, stable, osc2}), 64'b001);
    chk("t3_osc_gen", 64'(gen_count), 64'd2);
    chk("t3_osc_state", 64'(state), 64'd5);

    // 4: glider, pause at tick 2, three single steps, resume.
    seed = glider();
    b = cyc;
    push_we(b + 1, 1'b1); push_we(b + 5, 1'b0);
    pulse(P_START);
    run_to(b + 8);
    pulse(P_PAUSE);
    chk("t4_paused", 64'(state), 64'd3);
    run_to(b + 29);
    chk("t4_pause_gen", 64'(gen_count), 64'd1);
    for (int i = 0; i < 3; i++) begin
      s = cyc;
      push_we(s + 1, 1'b0);
      pulse(P_STEP);
      chk("t4_step_state", 64'(state), 64'd4);
      next_cyc();
      next_cyc();
    end
    chk("t4_step_gen", 64'(gen_count), 64'd4);
    chk("t4_back_pause", 64'(state), 64'd3);
    p = cyc;
    push_we(p + 2, 1'b0);
    pulse(P_PAUSE);
    chk("t4_resumed", 64'(state), 64'd2);
    run_to(p + 3);
    chk("t4_gen5", 64'(gen_count), 64'd5);
    chk("t4_grid", grid_m, evolve_n(glider(), 5));
    pulse(P_CLEAR);

    // 5: generation limit of 3 on the second instance.
    b = cyc;
    pulse(P_LSTART);
    chk("t5_load", 64'(l_state), 64'd1);
    run_to(b + 6);
    chk("t5_gen1", 64'(l_gen_count), 64'd1);
    run_to(b + 13);
    chk("t5_last_we", 64'(l_grid_we), 64'd1);
    run_to(b + 14);
    chk("t5_halt", 64'(l_state), 64'd5);
    chk("t5_gen3", 64'(l_gen_count), 64'd3);
    chk("t5_noflags", 64'({l_extinct, l_stable, l_osc2}), 64'd0);
    chk("t5_grid", grid_l, evolve_n(glider(), 3));
    run_to(b + 17);
    chk("t5_halt_we", 64'(l_grid_we), 64'd0);
    q = cyc;
    pulse(P_LSTART);
    chk("t5_reload", 64'(l_state), 64'd1);
    next_cyc();
    chk("t5_regen", 64'(l_gen_count), 64'd0);
    chk("t5_rerun", 64'(l_state), 64'd2);
    pulse(P_LCLEAR);

    // 6: reset mid-RUN at tick 2, then start+clear together.
    b = cyc;
    push_we(b + 1, 1'b1); push_we(b + 5, 1'b0);
    pulse(P_START);
    run_to(b + 8);
    flopreset = 1'b1;
    next_cyc();
    flopreset = 1'b0;
    chk_reset_vals("t6_rst");
    run_to(b + 15);
    start = 1'b1; clear = 1'b1;
    next_cyc();
    start = 1'b0; clear = 1'b0;
    chk("t6_startclr", 64'(state), 64'd0);
    next_cyc();
    chk("t6_still_idle", 64'(state), 64'd0);

    // Restart after reset: tick starts from zero again.
    b = cyc;
    push_we(b + 1, 1'b1); push_we(b + 5, 1'b0);
    pulse(P_START);
    run_to(b + 6);
    chk("t6_restart_gen", 64'(gen_count), 64'd1);
    pulse(P_CLEAR);
    next_cyc();
    next_cyc();
    chk("exp_left", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
